// File: rtl/pawc_wb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
// Holds the arbiter FSM state encoding, the master index constants and
// a helper that converts a master index into the one-hot grant vector.
package pawc_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TMO  = 2'd2
  } arb_state_e;

  localparam int M_CPU  = 0;
  localparam int M_BOOT = 1;

  // Master index (0 = CPU, 1 = boot/DMA loader) to one-hot grant.
  function automatic logic [1:0] onehot_grant(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Classic Wishbone bus bundle used to group one master or slave port.
//   cyc/stb/we/adr/dat_w/sel : driven by the master side
//   ack/err/dat_r            : driven by the slave side
// Handshake: a beat is offered while cyc && stb are high; the master holds
// every request field stable until the slave answers with ack (dat_r valid
// in that same cycle for reads) or err. One ack/err completes one beat;
// cyc stays high across all beats of a bus cycle and falls to release it.
interface wb_rr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic            err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, err, dat_r
  );
endinterface

// File: rtl/wb_arb_wdt.sv
// Bus watchdog for the arbiter: counts consecutive wait cycles of an
// un-answered strobe and flags the cycle in which the count reaches TIMEOUT.
//   clk      : rising-edge clock
//   resetn   : asynchronous active-low reset
//   count_en : this cycle is a wait cycle (busy, stb high, no ack/err)
//   clear    : restart the count (ack, err, stb low or not busy)
//   expired  : this wait cycle is the TIMEOUT-th one in a row
module wb_arb_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flag combinationally on the wait cycle that brings the count to
  // TIMEOUT, so an ack in that same cycle (count_en low) suppresses it.
  assign expired = count_en && (cnt >= LAST_WAIT);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin arbiter in front of one shared Wishbone slave.
// Master 0 is the CPU, master 1 the boot/DMA loader. A registered grant is
// taken one cycle after cyc rises, held for the whole bus cycle, and a
// watchdog forces a one-cycle error when a strobe stays un-answered.
//   clk, resetn              : clock, asynchronous active-low reset
//   m0_* / m1_*              : master-side classic Wishbone ports
//   s_*                      : shared-slave ports
//   grant                    : one-hot current owner (00 = none)
//   state                    : FSM state for debug (arb_state_e encoding)
module wb_rr_arbiter
  import pawc_wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      grant,
  output logic [1:0]      state
);

  arb_state_e st, st_nxt;
  logic [1:0] gnt, gnt_nxt;
  logic       last, last_nxt;   // index of the master granted last

  logic            g_cyc, g_stb, g_we;
  logic [AW-1:0]   g_adr;
  logic [DW-1:0]   g_dat;
  logic [DW/8-1:0] g_sel;

  logic wdt_count, wdt_clear, wdt_expired;
  logic pick_idx;

  // Signals of whichever master currently owns the bus.
  always_comb begin
    g_cyc = gnt[1] ? m1_cyc   : m0_cyc;
    g_stb = gnt[1] ? m1_stb   : m0_stb;
    g_we  = gnt[1] ? m1_we    : m0_we;
    g_adr = gnt[1] ? m1_adr   : m0_adr;
    g_dat = gnt[1] ? m1_dat_i : m0_dat_i;
    g_sel = gnt[1] ? m1_sel   : m0_sel;
  end

  // On a tie the master that did not own the bus last wins; otherwise the
  // only requester wins (m1_cyc alone selects index 1).
  assign pick_idx = (m0_cyc && m1_cyc) ? ~last : m1_cyc;

  always_comb begin
    st_nxt   = st;
    gnt_nxt  = gnt;
    last_nxt = last;
    case (st)
      ST_IDLE: begin
        if (m0_cyc || m1_cyc) begin
          st_nxt  = ST_BUSY;
          gnt_nxt = onehot_grant(pick_idx);
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          st_nxt   = ST_IDLE;
          gnt_nxt  = 2'b00;
          last_nxt = gnt[1];
        end else if (wdt_expired) begin
          st_nxt = ST_TMO;
        end
      end
      ST_TMO: begin
        if (!g_cyc) begin
          st_nxt   = ST_IDLE;
          gnt_nxt  = 2'b00;
          last_nxt = gnt[1];
        end else begin
          st_nxt = ST_BUSY;
        end
      end
      default: begin
        st_nxt  = ST_IDLE;
        gnt_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st   <= ST_IDLE;
      gnt  <= 2'b00;
      last <= 1'(M_BOOT);
    end else begin
      st   <= st_nxt;
      gnt  <= gnt_nxt;
      last <= last_nxt;
    end
  end

  assign wdt_count = (st == ST_BUSY) && g_stb && !s_ack && !s_err;
  assign wdt_clear = !wdt_count;

  wb_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk      (clk),
    .resetn   (resetn),
    .count_en (wdt_count),
    .clear    (wdt_clear),
    .expired  (wdt_expired)
  );

  // Bus routing. Only BUSY connects the owner to the slave; TMO hides the
  // strobe from the slave and answers the owner with err instead.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_o  = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_o = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_o = '0;
    if (st == ST_BUSY) begin
      s_cyc   = g_cyc;
      s_stb   = g_stb;
      s_we    = g_we;
      s_adr   = g_adr;
      s_dat_o = g_dat;
      s_sel   = g_sel;
      if (gnt[1]) begin
        m1_ack   = s_ack;
        m1_err   = s_err;
        m1_dat_o = s_dat_i;
      end else begin
        m0_ack   = s_ack;
        m0_err   = s_err;
        m0_dat_o = s_dat_i;
      end
    end else if (st == ST_TMO) begin
      if (gnt[1]) m1_err = 1'b1;
      else        m0_err = 1'b1;
    end
  end

  assign grant = gnt;
  assign state = st;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Testbench for wb_rr_arbiter: directed scenarios followed by randomized
// master/slave traffic, all checked cycle by cycle against a transaction-
// level model of ownership, round-robin order and the bus watchdog.
module tb_wb_rr_arbiter;
  import pawc_wb_pkg::*;

  localparam int AW          = 32;
  localparam int DW          = 32;
  localparam int SW          = DW / 8;
  localparam int TMO_CYC     = 8;
  localparam int RAND_CYCLES = 1500;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- buses and DUT ----------------
  wb_rr_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
  wb_rr_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
  wb_rr_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();
  logic [1:0] grant;
  logic [1:0] state;

  logic [1:0]    m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic          sl_ack, sl_err;
  logic [DW-1:0] sl_dat;

  assign m0_bus.cyc   = m_cyc[0];
  assign m0_bus.stb   = m_stb[0];
  assign m0_bus.we    = m_we[0];
  assign m0_bus.adr   = m_adr[0];
  assign m0_bus.dat_w = m_dat[0];
  assign m0_bus.sel   = m_sel[0];
  assign m1_bus.cyc   = m_cyc[1];
  assign m1_bus.stb   = m_stb[1];
  assign m1_bus.we    = m_we[1];
  assign m1_bus.adr   = m_adr[1];
  assign m1_bus.dat_w = m_dat[1];
  assign m1_bus.sel   = m_sel[1];
  assign s_bus.ack    = sl_ack;
  assign s_bus.err    = sl_err;
  assign s_bus.dat_r  = sl_dat;

  wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO_CYC)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0_cyc   (m0_bus.cyc),
    .m0_stb   (m0_bus.stb),
    .m0_we    (m0_bus.we),
    .m0_adr   (m0_bus.adr),
    .m0_dat_i (m0_bus.dat_w),
    .m0_sel   (m0_bus.sel),
    .m0_ack   (m0_bus.ack),
    .m0_err   (m0_bus.err),
    .m0_dat_o (m0_bus.dat_r),
    .m1_cyc   (m1_bus.cyc),
    .m1_stb   (m1_bus.stb),
    .m1_we    (m1_bus.we),
    .m1_adr   (m1_bus.adr),
    .m1_dat_i (m1_bus.dat_w),
    .m1_sel   (m1_bus.sel),
    .m1_ack   (m1_bus.ack),
    .m1_err   (m1_bus.err),
    .m1_dat_o (m1_bus.dat_r),
    .s_cyc    (s_bus.cyc),
    .s_stb    (s_bus.stb),
    .s_we     (s_bus.we),
    .s_adr    (s_bus.adr),
    .s_dat_o  (s_bus.dat_w),
    .s_sel    (s_bus.sel),
    .s_ack    (s_bus.ack),
    .s_err    (s_bus.err),
    .s_dat_i  (s_bus.dat_r),
    .grant    (grant),
    .state    (state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 none, else master index; last: master that owned the bus last;
  // waitc: consecutive un-answered strobe cycles of the owner.
  int owner, last, waitc;
  bit in_tmo;

  logic          e_s_cyc, e_s_stb, e_s_we, e_s_full, e_dat_chk;
  logic [AW-1:0] e_s_adr;
  logic [DW-1:0] e_s_dat;
  logic [SW-1:0] e_s_sel;
  logic [1:0]    e_grant, e_ack, e_err, e_state;
  logic [DW-1:0] e_dat [2];

  function automatic void model_reset();
    owner  = -1;
    last   = 1;
    waitc  = 0;
    in_tmo = 1'b0;
  endfunction

  function automatic void model_outputs();
    e_s_cyc = 1'b0; e_s_stb = 1'b0; e_s_we = 1'b0;
    e_s_adr = '0;   e_s_dat = '0;   e_s_sel = '0;
    e_grant = 2'b00; e_ack = 2'b00; e_err = 2'b00;
    e_dat[0] = '0;  e_dat[1] = '0;
    e_s_full = 1'b0; e_dat_chk = 1'b0;
    e_state = ST_IDLE;
    if (!resetn) begin
      e_s_full = 1'b1;
      return;
    end
    if (owner >= 0) begin
      e_grant[owner] = 1'b1;
      if (in_tmo) begin
        e_state = ST_TMO;
        e_err[owner] = 1'b1;
      end else begin
        e_state   = ST_BUSY;
        e_s_full  = 1'b1;
        e_dat_chk = 1'b1;
        e_s_cyc = m_cyc[owner];
        e_s_stb = m_stb[owner];
        e_s_we  = m_we[owner];
        e_s_adr = m_adr[owner];
        e_s_dat = m_dat[owner];
        e_s_sel = m_sel[owner];
        e_ack[owner] = sl_ack;
        e_err[owner] = sl_err;
        e_dat[owner] = sl_dat;
      end
    end
  endfunction

  function automatic void model_update();
    if (!resetn) begin
      model_reset();
      return;
    end
    if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
      else if (m_cyc[0])        owner = 0;
      else if (m_cyc[1])        owner = 1;
      waitc = 0;
    end else if (in_tmo) begin
      in_tmo = 1'b0;
      if (!m_cyc[owner]) begin last = owner; owner = -1; end
    end else if (!m_cyc[owner]) begin
      last = owner; owner = -1; waitc = 0;
    end else if (m_stb[owner] && !sl_ack && !sl_err) begin
      waitc++;
      if (waitc == TMO_CYC) begin in_tmo = 1'b1; waitc = 0; end
    end else begin
      waitc = 0;
    end
  endfunction

  // ---------------- cycle helpers ----------------
  // Inputs are driven 1 time unit after the rising edge; outputs are
  // sampled on the falling edge; the model advances on the rising edge.
  task automatic eval_cycle();
    model_outputs();
    @(negedge clk);
    check("grant", grant, e_grant);
    check("state", state, e_state);
    check("s_cyc", s_bus.cyc, e_s_cyc);
    check("s_stb", s_bus.stb, e_s_stb);
    if (e_s_full) begin
      check("s_we",  s_bus.we,    e_s_we);
      check("s_adr", s_bus.adr,   e_s_adr);
      check("s_dat", s_bus.dat_w, e_s_dat);
      check("s_sel", s_bus.sel,   e_s_sel);
    end
    check("m0_ack", m0_bus.ack, e_ack[0]);
    check("m0_err", m0_bus.err, e_err[0]);
    check("m1_ack", m1_bus.ack, e_ack[1]);
    check("m1_err", m1_bus.err, e_err[1]);
    if (e_dat_chk) begin
      check("m0_dat", m0_bus.dat_r, e_dat[0]);
      check("m1_dat", m1_bus.dat_r, e_dat[1]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      eval_cycle();
      advance();
    end
  endtask

  // ---------------- driver tasks ----------------
  int beats [2];
  bit slave_mute;

  task automatic set_master(input int i, input logic cyc, input logic we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc[i] = cyc;
    m_stb[i] = cyc;
    m_we[i]  = we;
    m_adr[i] = adr;
    m_dat[i] = dat;
    m_sel[i] = '1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_master(i, 1'b0, 1'b0, '0, '0);
      beats[i] = 0;
    end
    sl_ack = 1'b0; sl_err = 1'b0; sl_dat = '0;
    eval_cycle();
    advance();
    resetn = 1'b1;
  endtask

  task automatic new_beat(input int i);
    m_we[i]  = 1'($urandom_range(0, 1));
    m_adr[i] = AW'($urandom);
    m_dat[i] = DW'($urandom);
    m_sel[i] = SW'($urandom_range(1, (1 << SW) - 1));
  endtask

  // Masters react to the response expected in the previous cycle.
  task automatic drive_masters();
    for (int i = 0; i < 2; i++) begin
      if (!m_cyc[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
          beats[i] = $urandom_range(1, 4);
          new_beat(i);
        end
      end else if (e_err[i]) begin
        if ($urandom_range(0, 1) == 1) begin
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end
      end else if (e_ack[i]) begin
        beats[i]--;
        if (beats[i] == 0) begin
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end else begin
          new_beat(i);
          m_stb[i] = ($urandom_range(0, 3) != 0);
        end
      end else if (!m_stb[i]) begin
        m_stb[i] = 1'b1;
      end
    end
  endtask

  task automatic drive_slave();
    if ($urandom_range(0, 15) == 0) slave_mute = ~slave_mute;
    sl_ack = 1'b0;
    sl_err = 1'b0;
    sl_dat = DW'($urandom);
    if (e_s_stb && !slave_mute) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: sl_ack = 1'b1;
        4:          sl_err = 1'b1;
        default:    ;
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
    end
    sl_ack = 1'b0; sl_err = 1'b0; sl_dat = '0;
    slave_mute = 1'b0;
    model_reset();
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_state", state, ST_IDLE);
    check("rst_s_stb", s_bus.stb, 1'b0);

    // m0 single read, slave answers on the third strobe cycle
    do_reset();
    set_master(0, 1'b1, 1'b0, 32'h0000_0010, '0);
    eval_cycle();
    check("d1_no_stb_in_idle", s_bus.stb, 1'b0);
    advance();
    eval_cycle();
    check("d1_stb_after_1cyc", s_bus.stb, 1'b1);
    check("d1_s_adr", s_bus.adr, 32'h0000_0010);
    advance();
    cycles(1);
    sl_ack = 1'b1; sl_dat = 32'hDEAD_BEEF;
    eval_cycle();
    check("d1_ack", m0_bus.ack, 1'b1);
    check("d1_rdata", m0_bus.dat_r, 32'hDEAD_BEEF);
    check("d1_m1_quiet", {m1_bus.ack, m1_bus.err, m1_bus.dat_r}, '0);
    advance();
    set_master(0, 1'b0, 1'b0, '0, '0); sl_ack = 1'b0; sl_dat = '0;
    cycles(2);

    // simultaneous requests alternate, m0 first out of reset
    do_reset();
    set_master(0, 1'b1, 1'b0, 32'h20, '0);
    set_master(1, 1'b1, 1'b0, 32'h24, '0);
    cycles(1);
    sl_ack = 1'b1;
    eval_cycle();
    check("d2_first_m0", grant, 2'b01);
    advance();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; sl_ack = 1'b0;
    cycles(2);
    sl_ack = 1'b1;
    eval_cycle();
    check("d2_m1_within_2", grant, 2'b10);
    check("d2_m1_ack", m1_bus.ack, 1'b1);
    advance();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; sl_ack = 1'b0;
    cycles(2);
    set_master(0, 1'b1, 1'b0, 32'h28, '0);
    set_master(1, 1'b1, 1'b0, 32'h2C, '0);
    cycles(1);
    eval_cycle();
    check("d2_alternate_m0", grant, 2'b01);
    advance();
    set_master(0, 1'b0, 1'b0, '0, '0);
    set_master(1, 1'b0, 1'b0, '0, '0);
    cycles(3);

    // m1 4-beat write burst while m0 waits
    do_reset();
    set_master(1, 1'b1, 1'b1, 32'h100, 32'h1111_0000);
    cycles(1);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h200;
    for (int b = 0; b < 4; b++) begin
      m_adr[1] = 32'h100 + 32'(4 * b);
      m_dat[1] = DW'($urandom);
      sl_ack = 1'b1;
      eval_cycle();
      check("d3_grant_m1", grant, 2'b10);
      check("d3_beat_adr", s_bus.adr, 32'h100 + 32'(4 * b));
      check("d3_m0_waits", m0_bus.ack, 1'b0);
      advance();
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; sl_ack = 1'b0;
    cycles(2);
    eval_cycle();
    check("d3_m0_after_m1", grant, 2'b01);
    advance();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    cycles(2);

    // watchdog: slave never answers m0
    do_reset();
    set_master(0, 1'b1, 1'b0, 32'h40, '0);
    cycles(1);
    for (int k = 1; k <= TMO_CYC; k++) begin
      eval_cycle();
      check("d4_stb_wait", s_bus.stb, 1'b1);
      check("d4_no_early_err", m0_bus.err, 1'b0);
      advance();
    end
    eval_cycle();
    check("d4_err_pulse", m0_bus.err, 1'b1);
    check("d4_stb_hidden", s_bus.stb, 1'b0);
    advance();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    eval_cycle();
    check("d4_err_one_cycle", m0_bus.err, 1'b0);
    advance();
    eval_cycle();
    check("d4_back_idle", state, ST_IDLE);
    advance();

    // ack on the TIMEOUT-th wait cycle beats the watchdog
    do_reset();
    set_master(0, 1'b1, 1'b0, 32'h44, '0);
    cycles(1 + TMO_CYC - 1);
    sl_ack = 1'b1; sl_dat = 32'h1234_5678;
    eval_cycle();
    check("d5_late_ack", m0_bus.ack, 1'b1);
    check("d5_no_err", m0_bus.err, 1'b0);
    advance();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; sl_ack = 1'b0;
    eval_cycle();
    check("d5_no_err_after", m0_bus.err, 1'b0);
    advance();
    cycles(1);

    // asynchronous reset in the middle of an m1 burst
    do_reset();
    set_master(1, 1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5);
    cycles(1);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h400;
    sl_ack = 1'b1;
    cycles(1);
    #2;
    resetn = 1'b0;
    #1;
    check("d6_rst_grant", grant, 2'b00);
    check("d6_rst_s_cyc", s_bus.cyc, 1'b0);
    check("d6_rst_s_stb", s_bus.stb, 1'b0);
    check("d6_rst_m1_ack", m1_bus.ack, 1'b0);
    check("d6_rst_m0_ack", m0_bus.ack, 1'b0);
    eval_cycle();
    advance();
    resetn = 1'b1; sl_ack = 1'b0;
    cycles(1);
    eval_cycle();
    check("d6_m0_first", grant, 2'b01);
    advance();
    m_cyc = '0; m_stb = '0;
    cycles(2);

    // randomized traffic
    do_reset();
    slave_mute = 1'b0;
    e_ack = 2'b00; e_err = 2'b00;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      drive_masters();
      model_outputs();
      drive_slave();
      eval_cycle();
      advance();
    end
    m_cyc = '0; m_stb = '0; sl_ack = 1'b0; sl_err = 1'b0;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
